// File: rtl/sigmoid_alu_neuron_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_alu_neuron_accumulator
// Purpose  : Saturating signed MAC over N_INPUTS weight/activation beats per
//            neuron; hands accum + latched bias to the sigmoid calculator.
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid_alu_neuron_accumulator #(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 14,
  parameter int W_W      = 4,
  parameter int A_W      = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [W_W-1:0]   bias_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_W-1:0]   weight,
  input  logic [A_W-1:0]   activation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] accum,
  output logic [W_W-1:0]   bias,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int P_W   = W_W + A_W;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] accum_q;
  logic [W_W-1:0]   bias_q;
  logic [CNT_W-1:0] count_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [P_W-1:0]   wgt_ext;
  logic [P_W-1:0]   act_ext;
  logic [P_W-1:0]   prod;
  logic [ACC_W:0]   sum_d;
  logic [ACC_W-1:0] accum_d;
  logic             beat;

  // Low P_W bits of an unsigned product of sign/zero-extended operands equal the signed product.
  assign wgt_ext = {{A_W{weight[W_W-1]}}, weight};
  assign act_ext = {{W_W{1'b0}}, activation};
  assign prod    = wgt_ext * act_ext;

  assign sum_d = {accum_q[ACC_W-1], accum_q}
               + {{(ACC_W+1-P_W){prod[P_W-1]}}, prod};

  always_comb begin
    accum_d = sum_d[ACC_W-1:0];
    if (sum_d[ACC_W] != sum_d[ACC_W-1]) begin
      accum_d = sum_d[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign beat = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      accum_q     <= '0;
      bias_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            accum_q    <= '0;
            count_q    <= '0;
            bias_q     <= bias_in;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            accum_q <= accum_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_CNT) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign accum     = accum_q;
  assign bias      = bias_q;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_alu_neuron_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_alu_neuron_accumulator
// Purpose  : Scoreboard bench: 16-input instance for main behaviour, 80-input
//            instance for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_alu_neuron_accumulator;

  typedef struct packed {
    logic [13:0] acc;
    logic [3:0]  b;
  } exp_t;

  logic clk;
  logic n_rst;

  logic        start, in_valid, out_ready;
  logic [3:0]  bias_in, weight, activation;
  logic        in_ready, out_valid, busy;
  logic [13:0] accum;
  logic [3:0]  bias;

  logic        start_80, in_valid_80, out_ready_80;
  logic [3:0]  bias_in_80, weight_80, activation_80;
  logic        in_ready_80, out_valid_80, busy_80;
  logic [13:0] accum_80;
  logic [3:0]  bias_80;

  exp_t q16[$];
  exp_t q80[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sigmoid_alu_neuron_accumulator #(.N_INPUTS(16), .ACC_W(14), .W_W(4), .A_W(4)) u_dut16 (
    .clk(clk), .n_rst(n_rst), .start(start), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .weight(weight), .activation(activation),
    .out_valid(out_valid), .out_ready(out_ready), .accum(accum), .bias(bias), .busy(busy)
  );

  sigmoid_alu_neuron_accumulator #(.N_INPUTS(80), .ACC_W(14), .W_W(4), .A_W(4)) u_dut80 (
    .clk(clk), .n_rst(n_rst), .start(start_80), .bias_in(bias_in_80),
    .in_valid(in_valid_80), .in_ready(in_ready_80), .weight(weight_80),
    .activation(activation_80), .out_valid(out_valid_80), .out_ready(out_ready_80),
    .accum(accum_80), .bias(bias_80), .busy(busy_80)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop expected result on every output handshake.
  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        chk("sb16_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("sb16_accum", {18'd0, accum}, {18'd0, e.acc});
        chk("sb16_bias", {28'd0, bias}, {28'd0, e.b});
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && out_valid_80 && out_ready_80) begin
      if (q80.size() == 0) begin
        chk("sb80_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q80.pop_front();
        chk("sb80_accum", {18'd0, accum_80}, {18'd0, e.acc});
        chk("sb80_bias", {28'd0, bias_80}, {28'd0, e.b});
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic start16(input logic [3:0] b);
    bias_in = b;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic beat16(input logic [3:0] w, input logic [3:0] a, input int gap);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0; weight = 4'h7; activation = 4'hF;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; weight = w; activation = a;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("beat16_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake16;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs16_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run80(input logic [3:0] b, input logic [3:0] w_body,
                       input logic [3:0] w_last, input logic [13:0] exp_acc);
    q80.push_back('{acc: exp_acc, b: b});
    bias_in_80 = b; start_80 = 1'b1;
    @(posedge clk); #1;
    start_80 = 1'b0;
    activation_80 = 4'd15;
    for (int i = 0; i < 80; i++) begin
      in_valid_80 = 1'b1;
      weight_80   = (i == 79) ? w_last : w_body;
      @(posedge clk); #1;
    end
    in_valid_80 = 1'b0;
    chk("t4_out_valid", {31'd0, out_valid_80}, 32'd1);
    out_ready_80 = 1'b1;
    @(posedge clk); #1;
    out_ready_80 = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    start = 0; in_valid = 0; out_ready = 0; bias_in = 0; weight = 0; activation = 0;
    start_80 = 0; in_valid_80 = 0; out_ready_80 = 0; bias_in_80 = 0; weight_80 = 0;
    activation_80 = 0;
    #2;
    chk("rst_accum", {18'd0, accum}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Test 1: async reset mid-neuron
    start16(4'd3);
    for (int i = 0; i < 5; i++) beat16(4'd2, 4'd3, 0);
    chk("t1_busy_before", {31'd0, busy}, 32'd1);
    #3;
    n_rst = 1'b0;
    #1;
    chk("t1_accum", {18'd0, accum}, 32'd0);
    chk("t1_bias", {28'd0, bias}, 32'd0);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Test 2: 16 x (1*1), bias 3
    start16(4'd3);
    for (int i = 0; i < 15; i++) beat16(4'd1, 4'd1, 0);
    chk("t2_valid_before_last", {31'd0, out_valid}, 32'd0);
    beat16(4'd1, 4'd1, 0);
    chk("t2_latency", {31'd0, out_valid}, 32'd1);
    q16.push_back('{acc: 14'd16, b: 4'd3});
    handshake16();

    // Test 3: 16 x (-8*15), bias -8
    start16(4'b1000);
    for (int i = 0; i < 16; i++) beat16(4'h8, 4'd15, 0);
    q16.push_back('{acc: 14'h3880, b: 4'h8});
    handshake16();

    // Test 5: gaps, ignored starts, held output; 8*(2*5) + 8*(-3*7) = -88
    start16(4'd5);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        bias_in = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      beat16((i < 8) ? 4'd2 : 4'hD, (i < 8) ? 4'd5 : 4'd7, $urandom_range(0, 2));
    end
    q16.push_back('{acc: 14'h3FA8, b: 4'd5});
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_accum", {18'd0, accum}, 32'h3FA8);
      chk("t5_hold_bias", {28'd0, bias}, 32'd5);
      if (k == 2) begin bias_in = 4'd1; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
    end
    bias_in = 4'd9; start = 1'b1;
    handshake16();
    start = 1'b0;
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("t5_start_ignored_busy", {31'd0, busy}, 32'd0);
    chk("t5_start_ignored_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_bias_held", {28'd0, bias}, 32'd5);

    // Test 6: out_ready already high when DONE is reached
    out_ready = 1'b1;
    start16(4'd7);
    q16.push_back('{acc: 14'd192, b: 4'd7});
    for (int i = 0; i < 16; i++) beat16(4'd3, 4'd4, 0);
    chk("t6_valid_one_cycle", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t6_valid_dropped", {31'd0, out_valid}, 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    start16(4'd6);
    chk("t6_accum_cleared", {18'd0, accum}, 32'd0);
    chk("t6_bias_loaded", {28'd0, bias}, 32'd6);
    for (int i = 0; i < 16; i++) beat16(4'd0, 4'd9, 0);
    q16.push_back('{acc: 14'd0, b: 4'd6});
    handshake16();

    // Test 4: saturation on the 80-input instance
    run80(4'd1, 4'd7, 4'd7, 14'h1FFF);
    run80(4'hF, 4'h8, 4'h8, 14'h2000);
    run80(4'd2, 4'd7, 4'h8, 14'h1F87);   // clamp at +8191, then -120 brings it back

    for (int i = 0; i < 20 && (q16.size() != 0 || q80.size() != 0); i++) @(posedge clk);
    chk("sb16_drained", q16.size(), 32'd0);
    chk("sb80_drained", q80.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
